// File: rtl/decrypt_stream.sv
// Streaming LWE decryption core.
// Accumulates <a,s> over PARALLEL lanes per beat, then decodes
// m = round((b - <a,s>) mod q * t / q) mod t, or the raw low bits of the
// difference, and holds the result until the consumer accepts it.
module decrypt_stream #(
  parameter int PLAINTEXT_WIDTH  = 6,
  parameter int CIPHERTEXT_WIDTH = 10,
  parameter int DIMENSION        = 10,
  parameter int DIM_WIDTH        = 4,
  parameter int PARALLEL         = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [CIPHERTEXT_WIDTH-1:0]            b_in,
  input  logic                                   round_en,
  output logic                                   busy,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [CIPHERTEXT_WIDTH*PARALLEL-1:0]   secretkey_entry,
  input  logic [CIPHERTEXT_WIDTH*PARALLEL-1:0]   ciphertext_entry,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [PLAINTEXT_WIDTH-1:0]             result
);

  localparam int CW    = CIPHERTEXT_WIDTH;
  localparam int PW    = PLAINTEXT_WIDTH;
  localparam int BEATS = (DIMENSION + PARALLEL - 1) / PARALLEL;
  localparam int SHIFT = CW - PW;

  localparam logic [CW-1:0]        HALF      = CW'(1) << (SHIFT - 1);
  localparam logic [DIM_WIDTH-1:0] LAST_BEAT = DIM_WIDTH'(BEATS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]           state_q,  state_d;
  logic [CW-1:0]        acc_q,    acc_d;
  logic [DIM_WIDTH-1:0] beat_q,   beat_d;
  logic [CW-1:0]        b_q,      b_d;
  logic                 round_q,  round_d;
  logic [PW-1:0]        result_q, result_d;

  logic [CW-1:0] beat_sum;
  logic [CW-1:0] sk_lane;
  logic [CW-1:0] ct_lane;
  logic [CW-1:0] dot;
  logic [CW-1:0] diff;
  logic [CW-1:0] rounded;
  logic [PW-1:0] decoded;

  // Sum of this beat's lane products; lanes past the end of the vector are masked.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    beat_sum = '0;
    sk_lane  = '0;
    ct_lane  = '0;
    for (int k = 0; k < PARALLEL; k++) begin
      sk_lane = secretkey_entry[k*CW +: CW];
      ct_lane = ciphertext_entry[k*CW +: CW];
      // CW x CW multiply in a CW-wide context keeps only the low bits: the
      // product is taken mod q, which is what the modular sum needs.
      if ((int'(beat_q) * PARALLEL + k) < DIMENSION) begin
        beat_sum = beat_sum + sk_lane * ct_lane;
      end
    end
  end

  // Running dot product including the current beat, and the decoded plaintext.
  always_comb begin
    dot     = acc_q + beat_sum;
    diff    = b_q - dot;
    // Adding half a step before the shift rounds to nearest; the carry out of
    // the top bit is dropped so values just below q decode to 0.
    rounded = diff + HALF;
    decoded = round_q ? rounded[CW-1:SHIFT] : diff[PW-1:0];
  end

  // Next-state logic for the IDLE -> ACCUM -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    beat_d   = beat_q;
    b_d      = b_q;
    round_d  = round_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d     = b_in;
          round_d = round_en;
          acc_d   = '0;
          beat_d  = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = dot;
          if (beat_q == LAST_BEAT) begin
            result_d = decoded;
            state_d  = S_DONE;
          end else begin
            beat_d = beat_q + DIM_WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any decryption in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      beat_q   <= '0;
      b_q      <= '0;
      round_q  <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      acc_q    <= acc_d;
      beat_q   <= beat_d;
      b_q      <= b_d;
      round_q  <= round_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

endmodule
